// File: rtl/seg_display_scan.sv
// seg_display_scan: 4-digit multiplexed 7-segment scanner with a
// per-frame shadow capture and a dark guard interval at each slot start.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high
//   data[15:0] - four hex digits, digit i = data[4i+3:4i], digit 0 rightmost
//   dp_in[3:0] - decimal point request per digit, active-high
//   blank[3:0] - force digit dark, active-high
//   an[3:0]    - anode enables, active-low, at most one low
//   seg[6:0]   - cathodes {g,f,e,d,c,b,a}, active-low
//   dp         - decimal point cathode, active-low
//   frame_done - one-cycle pulse after each shadow capture
//
// Parameters: SCAN_TIME (cycles per slot, >= 2), GUARD_TIME (< SCAN_TIME).
// Build option: define SEG_LEADING_ZERO_BLANK_EN to darken leading zero
// digits (digit 0 is never suppressed).
module seg_display_scan #(
    parameter logic [19:0] SCAN_TIME  = 20'h1_ffff,
    parameter logic [19:0] GUARD_TIME = 20'h0_0fff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] data_sh_q, data_sh_d;
    logic [3:0]  dp_sh_q, dp_sh_d;
    logic [3:0]  blank_sh_q, blank_sh_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic        frame_done_q, frame_done_d;

    logic        capture;
    logic        wrap;
    logic        lz_dark;
    logic        dark;
    logic [3:0]  nib;

    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        wrap    = (cnt_q == SCAN_TIME - 20'd1);
        cnt_d   = wrap ? 20'd0 : cnt_q + 20'd1;
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
        capture = (cnt_q == 20'd0) && (idx_q == 2'd0);

        data_sh_d  = capture ? data  : data_sh_q;
        dp_sh_d    = capture ? dp_in : dp_sh_q;
        blank_sh_d = capture ? blank : blank_sh_q;

        frame_done_d = capture;

        // Decode from the post-capture shadow so a zero guard interval
        // still shows the freshly captured frame in its first cycle.
        nib = data_sh_d[{idx_q, 2'b00} +: 4];

        lz_dark = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd3:    lz_dark = (data_sh_d[15:12] == 4'h0);
            2'd2:    lz_dark = (data_sh_d[15:8] == 8'h00);
            2'd1:    lz_dark = (data_sh_d[15:4] == 12'h000);
            default: lz_dark = 1'b0;
        endcase
`endif

        dark = (cnt_q < GUARD_TIME) || blank_sh_d[idx_q] || lz_dark;

        an_d  = dark ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d = dark ? 7'h7F : hex_decode(nib);
        dp_d  = dark ? 1'b1 : ~dp_sh_d[idx_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            data_sh_q    <= '0;
            dp_sh_q      <= '0;
            blank_sh_q   <= '0;
            an_q         <= 4'b1111;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            data_sh_q    <= data_sh_d;
            dp_sh_q      <= dp_sh_d;
            blank_sh_q   <= blank_sh_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan: randomized and directed bench for seg_display_scan
// against a cycle-count based reference model.
module tb_seg_display_scan;

    localparam int S = 8;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_display_scan #(
        .SCAN_TIME (20'(S)),
        .GUARD_TIME(20'(G))
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .dp_in     (dp_in),
        .blank     (blank),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    logic [6:0] seg_tab [16];
    initial seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model: m_n counts clock edges since reset release.
    // Frame position is plain arithmetic on that count.
    int          m_n = 0;
    int          m_phase, m_slot, m_tick;
    logic [15:0] m_data = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    logic [3:0]  m_blank = 4'h0;
    logic [3:0]  m_nib;
    bit          m_lit, m_lz_ok;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic        e_fd = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_n = 0;
            m_data = 16'h0;
            m_dp = 4'h0;
            m_blank = 4'h0;
            e_an = 4'hF;
            e_seg = 7'h7F;
            e_dp = 1'b1;
            e_fd = 1'b0;
        end else begin
            m_phase = m_n % (4 * S);
            if (m_phase == 0) begin
                m_data = data;
                m_dp = dp_in;
                m_blank = blank;
            end
            m_slot = m_phase / S;
            m_tick = m_phase % S;
            m_nib = 4'((m_data >> (4 * m_slot)) & 16'hF);
`ifdef SEG_LEADING_ZERO_BLANK_EN
            m_lz_ok = (m_slot == 0) || ((m_data >> (4 * m_slot)) != 0);
`else
            m_lz_ok = 1'b1;
`endif
            m_lit = (m_tick >= G) && !m_blank[m_slot] && m_lz_ok;
            e_an = m_lit ? ~(4'b0001 << m_slot) : 4'hF;
            e_seg = m_lit ? seg_tab[m_nib] : 7'h7F;
            e_dp = m_lit ? ~m_dp[m_slot] : 1'b1;
            e_fd = (m_phase == 0);
            m_n++;
        end
    end

    // Wait for a frame_done pulse; outputs then reflect frame phase 0.
    task automatic sync_frame;
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_done !== 1'b1 && k < 100);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL sync_frame frame_done=%b want 1 within 100 cycles",
                     frame_done);
        end
    endtask

    task automatic test_reset;
        repeat (13) @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1
                || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold an=%b seg=%b dp=%b fd=%b want 1111 1111111 1 0",
                         an, seg, dp, frame_done);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || an !== 4'hF) begin
            errors++;
            $display("FAIL reset_release fd=%b an=%b want 1 1111",
                     frame_done, an);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulse_width fd=%b want 0", frame_done);
        end
    endtask

    task automatic test_digits;
        logic [6:0] want [4];
        int s;
        want = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        data = 16'h1234;
        dp_in = 4'h0;
        blank = 4'h0;
        sync_frame();
        for (int p = 1; p <= 64; p++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                errors++;
                $display("FAIL digits p=%0d got %b %b %b %b want %b %b %b %b",
                         p, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
            s = (p / S) % 4;
            if (p % S == 2) begin
                checks++;
                if (an !== ~(4'b0001 << s) || seg !== want[s] || dp !== 1'b1) begin
                    errors++;
                    $display("FAIL digit_slot%0d got %b %b %b want %b %b 1",
                             s, an, seg, dp, ~(4'b0001 << s), want[s]);
                end
            end
            if (p == 32) begin
                checks++;
                if (frame_done !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_period fd=%b want 1 at cycle 32",
                             frame_done);
                end
            end
        end
    endtask

    task automatic test_midframe;
        data = 16'h1234;
        sync_frame();
        for (int p = 1; p <= 48; p++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                errors++;
                $display("FAIL midframe p=%0d got %b %b %b %b want %b %b %b %b",
                         p, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
            if (p == 10) data = 16'hFFFF;
            if (p == 18) begin
                checks++;
                if (seg !== 7'b0100100) begin
                    errors++;
                    $display("FAIL midframe_slot2 seg=%b want 0100100", seg);
                end
            end
            if (p == 26) begin
                checks++;
                if (seg !== 7'b1111001) begin
                    errors++;
                    $display("FAIL midframe_slot3 seg=%b want 1111001", seg);
                end
            end
            if (p == 34) begin
                checks++;
                if (seg !== 7'b0001110 || an !== 4'b1110) begin
                    errors++;
                    $display("FAIL midframe_next an=%b seg=%b want 1110 0001110",
                             an, seg);
                end
            end
        end
    endtask

    task automatic test_blank_dp;
        data = 16'h1234;
        blank = 4'b0100;
        dp_in = 4'b0001;
        sync_frame();
        for (int p = 1; p <= 32; p++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                errors++;
                $display("FAIL blank_dp p=%0d got %b %b %b %b want %b %b %b %b",
                         p, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
            if (p == 2) begin
                checks++;
                if (dp !== 1'b0 || an !== 4'b1110) begin
                    errors++;
                    $display("FAIL dp_slot0 dp=%b an=%b want 0 1110", dp, an);
                end
            end
            if (p == 10) begin
                checks++;
                if (dp !== 1'b1 || an !== 4'b1101) begin
                    errors++;
                    $display("FAIL dp_slot1 dp=%b an=%b want 1 1101", dp, an);
                end
            end
            if (p == 18) begin
                checks++;
                if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
                    errors++;
                    $display("FAIL blank_slot2 an=%b seg=%b dp=%b want 1111 1111111 1",
                             an, seg, dp);
                end
            end
        end
        blank = 4'h0;
        dp_in = 4'h0;
    endtask

    task automatic test_leading_zero;
        logic [3:0] want_an3, want_an2;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        want_an3 = 4'b1111;
        want_an2 = 4'b1111;
`else
        want_an3 = 4'b0111;
        want_an2 = 4'b1011;
`endif
        data = 16'h0050;
        sync_frame();
        for (int p = 1; p <= 32; p++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                errors++;
                $display("FAIL lzb p=%0d got %b %b %b %b want %b %b %b %b",
                         p, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
            if (p == 2) begin
                checks++;
                if (seg !== 7'b1000000 || an !== 4'b1110) begin
                    errors++;
                    $display("FAIL lzb_slot0 an=%b seg=%b want 1110 1000000", an, seg);
                end
            end
            if (p == 10) begin
                checks++;
                if (seg !== 7'b0010010 || an !== 4'b1101) begin
                    errors++;
                    $display("FAIL lzb_slot1 an=%b seg=%b want 1101 0010010", an, seg);
                end
            end
            if (p == 18) begin
                checks++;
                if (an !== want_an2) begin
                    errors++;
                    $display("FAIL lzb_slot2 an=%b want %b", an, want_an2);
                end
            end
            if (p == 26) begin
                checks++;
                if (an !== want_an3) begin
                    errors++;
                    $display("FAIL lzb_slot3 an=%b want %b", an, want_an3);
                end
            end
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                errors++;
                $display("FAIL random c=%0d got %b %b %b %b want %b %b %b %b",
                         c, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 249) == 0) begin
                reset = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
                data = 16'($urandom);
                dp_in = 4'($urandom);
                blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                if ($urandom_range(0, 3) == 0) data = data & 16'h00FF;
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_digits();
        test_midframe();
        test_blank_dp();
        test_leading_zero();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_display_scan.md
SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

Interface
REQ-001 Parameter SCAN_TIME, default 20'h1_ffff: clk cycles per digit slot; legal range 2 to 2^20-1.
REQ-002 Parameter GUARD_TIME, default 20'h0_0fff: dark cycles at the start of each slot; 0 disables the dark interval; must be < SCAN_TIME.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data  input  16  four hex digits; digit i = data[4i+3:4i]; digit 0 is rightmost.
REQ-006 dp_in  input  4  decimal point request per digit, active-high.
REQ-007 blank  input  4  force digit i dark, active-high.
REQ-008 an  output  4  digit anode enables, active-low, at most one bit low.
REQ-009 seg  output  7  segment cathodes, active-low, {g,f,e,d,c,b,a}.
REQ-010 dp  output  1  decimal point cathode, active-low.
REQ-011 frame_done  output  1  one-cycle pulse marking a new shadow capture.

Function
REQ-012 The tick counter SHALL count 0..SCAN_TIME-1 and wrap to 0; the 2-bit digit index SHALL advance on each wrap, going 0,1,2,3,0.
REQ-013 In the cycle where counter==0 and index==0, the block SHALL capture data, dp_in and blank into shadow registers; the display SHALL use only shadow values, so changes mid-frame never appear before the next frame.
REQ-014 frame_done SHALL be high for exactly the one cycle after each capture edge.
REQ-015 All outputs SHALL be registered, lagging counter/index state by one cycle.
REQ-016 While counter < GUARD_TIME: an=4'b1111, seg=7'h7F, dp=1.
REQ-017 Otherwise an SHALL drive only bit [index] low, and seg SHALL show the hex decode of shadow digit[index].
REQ-018 Decode values: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 dp SHALL equal ~shadow dp_in[index] outside the guard interval.
REQ-020 If shadow blank[index]=1, the slot SHALL be fully dark: an=1111, seg=7F, dp=1.

Reset
REQ-021 While reset is high: counter=0, index=0, shadows=0, an=4'b1111, seg=7'h7F, dp=1, frame_done=0.
REQ-022 The first rising edge after reset release SHALL perform a capture (REQ-013); asserting reset mid-slot SHALL abort the slot immediately with no partial state kept.

Configuration
REQ-023 Macro SEG_LEADING_ZERO_BLANK_EN defined: digit i (i=3,2,1) SHALL be dark when its shadow nibble and every higher shadow nibble are zero; digit 0 is never suppressed. The blank input still applies.
REQ-024 Macro undefined: no zero suppression; only blank darkens digits.

Verification (sim: SCAN_TIME=8, GUARD_TIME=2)
REQ-025 Assert reset for 3 cycles, mid-slot -> an=1111, seg=7F, dp=1 during reset; frame_done pulses 1 cycle after release.
REQ-026 data=16'h1234, dp_in=0, blank=0 -> slot 0 shows an=1110, seg=0011001; slot 1 shows an=1101, seg=0110000; slot 2 shows 1011 / 0100100; slot 3 shows 0111 / 1111001; dp=1 in every slot.
REQ-027 Guard check -> an=1111 for 2 cycles, then a valid digit for 6 cycles, in every slot; frame_done period is 32 cycles.
REQ-028 data changed from 16'h1234 to 16'hFFFF during slot 1 -> slots 2 and 3 still show 2 and 1; F is shown starting in slot 0 of the next frame.
REQ-029 blank=4'b0100, dp_in=4'b0001 -> slot 2 dark; dp=0 only in slot 0.
REQ-030 With SEG_LEADING_ZERO_BLANK_EN defined, data=16'h0050 -> slots 3 and 2 dark, slot 1 seg=0010010, slot 0 seg=1000000; with the macro undefined, all four digits are lit.
